// File: rtl/blood_type_serial_loader.sv
// ----------------------------------------------------------------------------
// blood_type_serial_loader
//
// Intake stage in front of the blood type classifier. It receives 3-bit codes
// on an asynchronous, idle-high serial line. Each frame is start(0), d0, d1,
// d2 (LSB first), an even parity bit, and stop(1). The stage checks framing
// and parity. Good codes go into a small FIFO, and the FIFO is drained through
// a valid/ready handshake. Every rejected frame produces a one-cycle pulse and
// bumps a saturating error counter.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_serial_in    serial line, idle high, asynchronous to i_clk
//   o_type_out     FIFO head code {bit2,bit1,bit0}; 0 while the FIFO is empty
//   o_type_valid   FIFO is non-empty
//   i_type_ready   consumer accepts o_type_out this cycle
//   o_fifo_count   number of stored entries
//   o_parity_err   one-cycle pulse: frame dropped because of bad parity
//   o_frame_err    one-cycle pulse: frame dropped because the stop bit was 0
//   o_overflow     one-cycle pulse: good frame dropped because the FIFO was full
//   o_err_count    saturating count of all error pulses
// ----------------------------------------------------------------------------
module blood_type_serial_loader #(
  parameter int BIT_CYCLES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_serial_in,
  output logic [2:0]                    o_type_out,
  output logic                          o_type_valid,
  input  logic                          i_type_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [ERR_W-1:0]              o_err_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CYC_W = $clog2(BIT_CYCLES);
  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  // Synchronizer. It resets low so that arming needs a real high level on the
  // line and is not caused by the reset value.
  logic r_sync1, r_sync2;
  logic w_s;

  // Receiver state.
  state_t           r_state, w_state_nxt;
  logic [CYC_W-1:0] r_cyc,   w_cyc_nxt;
  logic [1:0]       r_bit,   w_bit_nxt;
  logic [2:0]       r_shift, w_shift_nxt;
  logic             r_par,   w_par_nxt;
  logic             r_armed, w_armed_nxt;
  logic             w_eval;

  // FIFO state.
  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  // Decision signals.
  logic w_pop, w_push, w_full;
  logic w_frame_bad, w_par_bad, w_ovf;

  // Error outputs.
  logic             r_parity_err, r_frame_err, r_overflow;
  logic [ERR_W-1:0] r_err_count;

  // ---- synchronizer stage ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  // ---- receiver FSM: state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // ---- receiver FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_armed_nxt = r_armed;
    w_eval      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt = '0;
        w_bit_nxt = '0;
        // Arming only after a high level stops a stuck-low line, or the tail
        // of a frame with a bad stop bit, from looking like a new start bit.
        if (w_s)          w_armed_nxt = 1'b1;
        else if (r_armed) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cyc == HALF_LAST) begin
          w_cyc_nxt   = '0;
          w_state_nxt = w_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cyc == BIT_LAST) begin
          w_cyc_nxt = '0;
          // Shift in from the top so that d0 ends up in bit 0.
          w_shift_nxt = {w_s, r_shift[2:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 2'd2) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (r_cyc == BIT_LAST) begin
          w_cyc_nxt   = '0;
          w_par_nxt   = w_s;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cyc == BIT_LAST) begin
          w_cyc_nxt   = '0;
          w_eval      = 1'b1;
          w_armed_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
        w_armed_nxt = 1'b0;
      end
    endcase
  end

  // The stop bit is judged from the live synced sample in the evaluation
  // cycle. The checks are ordered frame > parity > overflow.
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = o_type_valid && i_type_ready;
  assign w_frame_bad = w_eval && !w_s;
  assign w_par_bad   = w_eval && w_s && (^{r_shift, r_par});
  // A pop in the evaluation cycle frees a slot, so a full FIFO still accepts.
  assign w_ovf       = w_eval && w_s && !(^{r_shift, r_par}) && w_full && !w_pop;
  assign w_push      = w_eval && w_s && !(^{r_shift, r_par}) && (!w_full || w_pop);

  // ---- FIFO storage (data only, not reset) ----
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  // ---- FIFO pointers and occupancy ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- error pulse / counter stage ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_frame_err  <= w_frame_bad;
      r_parity_err <= w_par_bad;
      r_overflow   <= w_ovf;
      // At most one error source is active per frame.
      if (w_frame_bad || w_par_bad || w_ovf) r_err_count <= sat_inc(r_err_count);
    end
  end

  assign o_type_valid = (r_count != '0);
  // The head is masked while empty so that reset and empty states read 0.
  assign o_type_out   = o_type_valid ? r_mem[r_rptr] : 3'b000;
  assign o_fifo_count = r_count;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_blood_type_serial_loader.sv
// ----------------------------------------------------------------------------
// tb_blood_type_serial_loader
//
// Drives serial frames bit by bit. A queue-based reference model predicts
// which frames are stored, which error pulse each frame raises, and the
// saturating error count. The bench uses a narrow error counter so that
// saturation is reached within the random section.
// ----------------------------------------------------------------------------
module tb_blood_type_serial_loader;

  localparam int BC    = 16;
  localparam int HALF  = BC / 2;
  localparam int DEPTH = 4;
  localparam int EW    = 4;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serial_in = 1'b1;
  logic          type_ready = 1'b0;
  logic [2:0]    type_out;
  logic          type_valid;
  logic [2:0]    fifo_count;
  logic          parity_err, frame_err, overflow;
  logic [EW-1:0] err_count;

  blood_type_serial_loader #(.BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH), .ERR_W(EW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_serial_in  (serial_in),
    .o_type_out   (type_out),
    .o_type_valid (type_valid),
    .i_type_ready (type_ready),
    .o_fifo_count (fifo_count),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow),
    .o_err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Cumulative pulse counters; each frame check compares the change in them.
  int c_par = 0, c_frm = 0, c_ovf = 0;
  always @(posedge clk) begin
    if (parity_err) c_par <= c_par + 1;
    if (frame_err)  c_frm <= c_frm + 1;
    if (overflow)   c_ovf <= c_ovf + 1;
  end

  // Reference model.
  int q[$];
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_err();
    return (m_err > EMAX) ? EMAX : m_err;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), q.size());
    chk({tag, ".valid"}, 32'(type_valid), (q.size() > 0) ? 1 : 0);
    chk({tag, ".head"},  32'(type_out),   (q.size() > 0) ? q[0] : 0);
    chk({tag, ".errc"},  32'(err_count),  exp_err());
  endtask

  // Sends one frame. When pop_at_stop is set, type_ready is high for exactly
  // the cycle in which the stop bit is judged.
  task automatic send_frame(input string tag, input logic [2:0] code,
                            input bit bad_par, input bit bad_stop, input bit pop_at_stop);
    int p0, f0, o0;
    int e_par, e_frm, e_ovf;
    logic p;
    p0 = c_par; f0 = c_frm; o0 = c_ovf;
    p  = (^code) ^ bad_par;
    @(negedge clk) serial_in = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      serial_in = code[i];
      repeat (BC) @(negedge clk);
    end
    serial_in = p;
    repeat (BC) @(negedge clk);
    serial_in = !bad_stop;
    if (pop_at_stop) begin
      repeat (HALF + 2) @(negedge clk);
      type_ready = 1'b1;
      if (q.size() > 0) chk({tag, ".pophead"}, 32'(type_out), q[0]);
      @(negedge clk) type_ready = 1'b0;
      repeat (BC - HALF - 3) @(negedge clk);
    end else begin
      repeat (BC) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (6) @(negedge clk);
    // Model: a pop in the evaluation cycle happens first, then the frame is
    // judged in priority order.
    if (pop_at_stop && q.size() > 0) void'(q.pop_front());
    e_par = 0; e_frm = 0; e_ovf = 0;
    if (bad_stop)                 e_frm = 1;
    else if (bad_par)             e_par = 1;
    else if (q.size() == DEPTH)   e_ovf = 1;
    else                          q.push_back(int'(code));
    m_err += e_par + e_frm + e_ovf;
    chk({tag, ".perr"}, c_par - p0, e_par);
    chk({tag, ".ferr"}, c_frm - f0, e_frm);
    chk({tag, ".ovf"},  c_ovf - o0, e_ovf);
    check_state(tag);
  endtask

  task automatic pop_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) type_ready = 1'b1;
      if (q.size() > 0) chk({tag, ".out"}, 32'(type_out), q[0]);
      @(negedge clk) type_ready = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
    end
    check_state(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out"},   32'(type_out),   0);
    chk({tag, ".valid"}, 32'(type_valid), 0);
    chk({tag, ".count"}, 32'(fifo_count), 0);
    chk({tag, ".pulses"}, 32'({parity_err, frame_err, overflow}), 0);
    chk({tag, ".errc"},  32'(err_count),  0);
  endtask

  initial begin
    int p0, f0, o0;
    logic [2:0] code;
    bit bp, bs, pa;

    // Test 1: reset state, then a single good frame.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame("t1", 3'b011, 0, 0, 0);

    // Test 2: overflow on the fifth frame, then drain in order.
    pop_n("t2pre", 1);
    send_frame("t2a", 3'b000, 0, 0, 0);
    send_frame("t2b", 3'b001, 0, 0, 0);
    send_frame("t2c", 3'b010, 0, 0, 0);
    send_frame("t2d", 3'b011, 0, 0, 0);
    send_frame("t2e", 3'b100, 0, 0, 0);
    pop_n("t2drain", 4);

    // Test 3: parity error, and frame error that wins over bad parity.
    send_frame("t3par", 3'b101, 1, 0, 0);
    send_frame("t3frm", 3'b110, 1, 1, 0);

    // Test 4: short low glitch is ignored, then a good frame.
    p0 = c_par; f0 = c_frm; o0 = c_ovf;
    @(negedge clk) serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * BC) @(negedge clk);
    chk("t4.pulses", (c_par - p0) + (c_frm - f0) + (c_ovf - o0), 0);
    check_state("t4glitch");
    send_frame("t4", 3'b111, 0, 0, 0);

    // Test 5: full FIFO, pop in the evaluation cycle, push is accepted.
    send_frame("t5f1", 3'b001, 0, 0, 0);
    send_frame("t5f2", 3'b100, 0, 0, 0);
    send_frame("t5f3", 3'b110, 0, 0, 0);
    send_frame("t5", 3'b010, 0, 0, 1);

    // Test 6: reset in the middle of a frame with two entries stored.
    pop_n("t6pre", 2);
    @(negedge clk) serial_in = 1'b0;
    repeat (BC) @(negedge clk);
    serial_in = 1'b1;
    repeat (BC + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("t6rst");
    q.delete();
    m_err = 0;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame("t6", 3'b001, 0, 0, 0);

    // Random section: mixed good and bad frames, occasional drains, and
    // pops in the evaluation cycle; err_count saturates along the way.
    for (int n = 0; n < 60; n++) begin
      code = 3'($urandom_range(0, 7));
      bp   = ($urandom_range(0, 4) == 0);
      bs   = ($urandom_range(0, 5) == 0);
      pa   = ($urandom_range(0, 3) == 0);
      send_frame("rnd", code, bp, bs, pa);
      if ($urandom_range(0, 2) == 0) pop_n("rndpop", $urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
